// File: rtl/frame_loader_pkg.sv
// rtl/frame_loader_pkg.sv - shared constants and state encoding for the frame loader
package frame_loader_pkg;

  // Loader FSM encoding, also decoded by the search controller.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_CUR = 2'd1,
    LOAD_REF = 2'd2,
    KICK     = 2'd3
  } state_t;

  localparam int CUR_WORDS_DEF  = 64;
  localparam int CUR_AW_DEF     = 8;
  localparam int REF_AW_DEF     = 8;
  localparam int R_W_DEF        = 2;
  localparam int REF_UNIT       = 64;
  localparam int BYTES_PER_WORD = 8;

  // Reference words loaded for a given search-range code.
  function automatic int ref_words(input int r_code);
    return REF_UNIT * (r_code + 1);
  endfunction

endpackage

// File: rtl/frame_loader_if.sv
// rtl/frame_loader_if.sv - pixel byte stream and memory write ports of the loader
interface frame_loader_if #(
  parameter int CUR_AW = 8,
  parameter int REF_AW = 8
) ();

  // Pixel byte stream into the loader
  logic              pix_valid;
  logic [7:0]        pix;
  logic              pix_ready;

  // Current-block memory write port
  logic              wenCur;
  logic [CUR_AW-1:0] addrCur;
  logic [63:0]       wdatCur;

  // Reference memory write port
  logic              wenRef;
  logic [REF_AW-1:0] addrRef;
  logic [63:0]       wdatRef;

  // Loader side: consumes bytes, produces memory writes
  modport master (
    input  pix_valid,
    input  pix,
    output pix_ready,
    output wenCur,
    output addrCur,
    output wdatCur,
    output wenRef,
    output addrRef,
    output wdatRef
  );

  // Source/memory side
  modport slave (
    output pix_valid,
    output pix,
    input  pix_ready,
    input  wenCur,
    input  addrCur,
    input  wdatCur,
    input  wenRef,
    input  addrRef,
    input  wdatRef
  );

endinterface

// File: rtl/frame_loader_byte_packer.sv
// rtl/frame_loader_byte_packer.sv - little-endian 8-to-64 byte packer with word-complete strobe
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [63:0] word_o,
  output logic        word_done_o
);

  // Only the first seven bytes need storage; the eighth is taken straight
  // from the input so the full word is ready in the accepting cycle.
  logic [2:0]  cnt_q, cnt_d;
  logic [55:0] pack_q, pack_d;

  // Bytes enter at the top and shift down, so the first byte ends up in [7:0]
  always_comb begin
    cnt_d  = cnt_q;
    pack_d = pack_q;
    if (clear_i) begin
      cnt_d = 3'd0;
    end else if (byte_valid_i) begin
      cnt_d  = cnt_q + 3'd1;
      pack_d = {byte_i, pack_q[55:8]};
    end
  end

  // Counter and partial-word register; a reset discards any partial word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 3'd0;
      pack_q <= 56'd0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
    end
  end

  assign word_o      = {byte_i, pack_q};
  assign word_done_o = byte_valid_i && !clear_i && (cnt_q == 3'd7);

endmodule

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - loads the current block and reference window, then kicks the search
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int CUR_WORDS = CUR_WORDS_DEF,
  parameter int CUR_AW    = CUR_AW_DEF,
  parameter int REF_AW    = REF_AW_DEF,
  parameter int R_W       = R_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [R_W-1:0] r,
  output logic           go,
  output logic           busy,
  frame_loader_if.master bus
);

  // Word index is wide enough for the larger region plus one bit of headroom
  localparam int IW = ((CUR_AW > REF_AW) ? CUR_AW : REF_AW) + 1;
  localparam logic [IW-1:0] CUR_LAST = IW'(CUR_WORDS - 1);

  state_t            state_q, state_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic              done_q, done_d;
  logic              wen_cur_q, wen_cur_d;
  logic              wen_ref_q, wen_ref_d;
  logic [CUR_AW-1:0] addr_cur_q, addr_cur_d;
  logic [REF_AW-1:0] addr_ref_q, addr_ref_d;
  logic [63:0]       wdat_cur_q, wdat_cur_d;
  logic [63:0]       wdat_ref_q, wdat_ref_d;

  logic              pix_ready;
  logic              accept;
  logic              start_ok;
  logic              word_done;
  logic [63:0]       word;
  logic [IW-1:0]     ref_last;

  assign start_ok = (state_q == IDLE) && start;
  assign accept   = bus.pix_valid && pix_ready;
  assign ref_last = IW'(ref_words(int'(r_q)) - 1);

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_ok),
    .byte_valid_i (accept),
    .byte_i       (bus.pix),
    .word_o       (word),
    .word_done_o  (word_done)
  );

  // FSM next state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    go        = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_CUR;
      end
      LOAD_CUR: begin
        pix_ready = 1'b1;
        // Switch region on the last current byte so the next cycle can take a reference byte
        if (word_done && (widx_q == CUR_LAST)) state_d = LOAD_REF;
      end
      LOAD_REF: begin
        // done_q marks the cycle the last reference word is on the write port
        pix_ready = !done_q;
        if (done_q) state_d = KICK;
      end
      KICK: begin
        go      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Word index, range latch and registered memory write ports
  always_comb begin
    r_d        = r_q;
    widx_d     = widx_q;
    done_d     = done_q;
    wen_cur_d  = 1'b0;
    wen_ref_d  = 1'b0;
    addr_cur_d = addr_cur_q;
    addr_ref_d = addr_ref_q;
    wdat_cur_d = wdat_cur_q;
    wdat_ref_d = wdat_ref_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d    = r;
          widx_d = '0;
          done_d = 1'b0;
        end
      end
      LOAD_CUR: begin
        if (word_done) begin
          wen_cur_d  = 1'b1;
          addr_cur_d = widx_q[CUR_AW-1:0];
          wdat_cur_d = word;
          widx_d     = (widx_q == CUR_LAST) ? '0 : widx_q + IW'(1);
        end
      end
      LOAD_REF: begin
        if (word_done) begin
          wen_ref_d  = 1'b1;
          addr_ref_d = widx_q[REF_AW-1:0];
          wdat_ref_d = word;
          widx_d     = widx_q + IW'(1);
          if (widx_q == ref_last) done_d = 1'b1;
        end
      end
      KICK: begin
        done_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears every write port and discards a partial load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q        <= '0;
      widx_q     <= '0;
      done_q     <= 1'b0;
      wen_cur_q  <= 1'b0;
      wen_ref_q  <= 1'b0;
      addr_cur_q <= '0;
      addr_ref_q <= '0;
      wdat_cur_q <= 64'd0;
      wdat_ref_q <= 64'd0;
    end else begin
      r_q        <= r_d;
      widx_q     <= widx_d;
      done_q     <= done_d;
      wen_cur_q  <= wen_cur_d;
      wen_ref_q  <= wen_ref_d;
      addr_cur_q <= addr_cur_d;
      addr_ref_q <= addr_ref_d;
      wdat_cur_q <= wdat_cur_d;
      wdat_ref_q <= wdat_ref_d;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.wenCur    = wen_cur_q;
  assign bus.addrCur   = addr_cur_q;
  assign bus.wdatCur   = wdat_cur_q;
  assign bus.wenRef    = wen_ref_q;
  assign bus.addrRef   = addr_ref_q;
  assign bus.wdatRef   = wdat_ref_q;

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL take parameter CUR_WORDS, default 64, meaning the number of 64-bit current-block words per load.
REQ-002 SHALL take parameter CUR_AW, default 8, meaning the current-memory address width.
REQ-003 SHALL take parameter REF_AW, default 8, meaning the reference-memory address width.
REQ-004 SHALL take parameter R_W, default 2, meaning the search-range code width.
REQ-005 SHALL have port clk, input, width 1: the single clock.
REQ-006 SHALL have port reset, input, width 1: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, width 1: begin a load, honoured in IDLE only.
REQ-008 SHALL have port r, input, width R_W: search-range code, sampled on accepted start.
REQ-009 SHALL have port pix_valid, input, width 1: pixel byte present.
REQ-010 SHALL have port pix, input, width 8: pixel byte.
REQ-011 SHALL have port pix_ready, output, width 1: loader accepts a byte this cycle.
REQ-012 SHALL have port wenCur, output, width 1: current-memory write enable.
REQ-013 SHALL have port addrCur, output, width CUR_AW: current-memory write address.
REQ-014 SHALL have port wdatCur, output, width 64: current-memory write data.
REQ-015 SHALL have port wenRef, output, width 1: reference-memory write enable.
REQ-016 SHALL have port addrRef, output, width REF_AW: reference-memory write address.
REQ-017 SHALL have port wdatRef, output, width 64: reference-memory write data.
REQ-018 SHALL have port go, output, width 1: one-cycle pulse that launches the search controller.
REQ-019 SHALL have port busy, output, width 1: high in any state other than IDLE.

Function
REQ-020 SHALL use FSM states IDLE, LOAD_CUR, LOAD_REF and KICK.
REQ-021 SHALL transition IDLE->LOAD_CUR on start; LOAD_CUR->LOAD_REF when current word CUR_WORDS-1 is written; LOAD_REF->KICK when the last reference word is written; KICK->IDLE unconditionally.
REQ-022 SHALL set the reference word count to 64*(r_q+1), with r_q the latched r: 64, 128, 192 or 256 words.
REQ-023 SHALL drive pix_ready high exactly in LOAD_CUR and LOAD_REF, and SHALL drop it in the cycle after the final byte of the last reference word is accepted.
REQ-024 SHALL count a byte transfer only when pix_valid and pix_ready are both high; pix_valid while pix_ready is low SHALL be ignored with no state change.
REQ-025 SHALL pack bytes little-endian: the first accepted byte goes to bits [7:0] and the eighth to bits [63:56], matching the controller's byte-0-first extraction.
REQ-026 SHALL assert wenCur or wenRef for exactly one cycle, in the cycle after the eighth byte of a word is accepted, with the registered packed word and address.
REQ-027 SHALL start addresses at 0 at the beginning of each region and increment them by 1 per written word; the reference address SHALL NOT wrap within a load (255 is the maximum, at r=3).
REQ-028 SHALL let the first reference byte be accepted in the cycle immediately after the last current byte; the byte counter SHALL restart at 0 at the region change with no bubble.
REQ-029 SHALL sustain a full rate of one byte per cycle; partial-word bytes SHALL be held across idle valid gaps of any length.
REQ-030 SHALL pulse go for exactly one cycle in KICK, never overlapping wenCur or wenRef.
REQ-031 SHALL ignore start while busy; r changes after start SHALL have no effect.
REQ-032 SHALL hold wenCur, wenRef, go and pix_ready low in IDLE; wdat and addr values are don't-care whenever the matching wen is low.

Reset
REQ-033 SHALL, on reset low, clear immediately (asynchronously): state=IDLE, byte counter=0, pack register=0, addrCur=0, addrRef=0, wdatCur=0, wdatRef=0, wenCur=0, wenRef=0, go=0, busy=0, pix_ready=0.
REQ-034 SHALL, on reset mid-load, discard any partial word and issue no write or go afterward; the next start SHALL begin from address 0.

Structure
REQ-035 SHALL take the shared constants (state encodings, CUR_WORDS default, the address widths, R_W and the reference-words-per-r unit of 64) from the common parameters include file shared with the search controller.
REQ-036 SHALL use one sub-module, byte_packer (8-to-64 shift/pack with a word-complete strobe), instantiated once and reused for both regions.

Verification
REQ-037 SHALL cover: start with r=0 and bytes 0x00..0xFF repeating at full rate -> 64 Cur writes; Cur word 0 = 0x0706050403020100 at addrCur 0; 64 Ref writes; then one go pulse; busy low 1 cycle after go.
REQ-038 SHALL cover: r=3 -> exactly 256 Ref writes, last at addrRef 255, with no write at address 0 after the first.
REQ-039 SHALL cover: pix_valid toggled randomly at about 50% -> write data identical to the full-rate run, with total accepted bytes = 8*(64+64*(r+1)).
REQ-040 SHALL cover: start pulsed again, with r changed, during LOAD_REF -> no restart; the word count follows the originally latched r.
REQ-041 SHALL cover: reset asserted after 13 current bytes, then released, then a new start -> no stray write; the first write is at addrCur 0 and holds the new bytes.
REQ-042 SHALL cover: the transition from the last Cur byte to the first Ref byte with pix_valid held high -> wenCur for word 63 followed by Ref word 0 containing the next 8 bytes, with no dropped bytes.
